// File: rtl/booth_mult32.sv
// Sequential radix-2 Booth 32x32 signed multiplier; optional HI word port under BOOTH_HI_EN.
// Latency: 32 cycles from the start edge to a one-cycle data_resultRDY pulse.
// No backpressure: a new ctrl_MULT pulse always wins and aborts any operation in flight.

module booth_cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c0,
    output logic [31:0] o_sum,
    output logic        o_ovf
);
    logic [31:0] w_b;
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    // Carry-in doubles as the subtract select: B is inverted and the +1 enters here.
    always_comb begin
        w_b    = i_b ^ {32{i_c0}};
        w_g    = i_a & w_b;
        w_p    = i_a ^ w_b;
        w_c    = '0;
        w_c[0] = i_c0;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
        end
        o_sum = w_p ^ w_c[31:0];
        o_ovf = w_c[32] ^ w_c[31];
    end
endmodule

module booth_mult32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
`ifdef BOOTH_HI_EN
    ,
    output logic [31:0] data_resultHI
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_m;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic        r_q1;
    logic [5:0]  r_count;
    logic [31:0] r_result;
    logic        r_exc;
`ifdef BOOTH_HI_EN
    logic [31:0] r_hi;
`endif

    logic        w_last;
    logic        w_add;
    logic [31:0] w_sum;
    logic        w_ovf;
    logic [31:0] w_mid;
    logic        w_sign;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_q_nxt;
    logic        w_exc_nxt;

    booth_cla32 u_add (
        .i_a   (r_acc),
        .i_b   (r_m),
        .i_c0  (r_q[0]),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last      = (r_state == S_RUN) && (r_count == 6'd31);
        if (ctrl_MULT) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_RUN:   if (w_last) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Sign of the 33-bit partial product is taken past any adder overflow,
    // which keeps the -2^31 multiplicand exact without a special case.
    always_comb begin
        w_add     = r_q[0] ^ r_q1;
        w_mid     = w_add ? w_sum : r_acc;
        w_sign    = w_add ? (w_sum[31] ^ w_ovf) : r_acc[31];
        w_acc_nxt = {w_sign, w_mid[31:1]};
        w_q_nxt   = {w_mid[0], r_q[31:1]};
        w_exc_nxt = !((&{w_acc_nxt, w_q_nxt[31]}) || !(|{w_acc_nxt, w_q_nxt[31]}));
    end

    always_ff @(posedge clock) begin
        if (reset || ctrl_MULT) begin
            r_m      <= reset ? 32'd0 : data_operandA;
            r_q      <= reset ? 32'd0 : data_operandB;
            r_acc    <= '0;
            r_q1     <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
`ifdef BOOTH_HI_EN
            r_hi     <= '0;
`endif
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_q1    <= r_q[0];
            r_count <= r_count + 6'd1;
            if (w_last) begin
                r_result <= w_q_nxt;
                r_exc    <= w_exc_nxt;
`ifdef BOOTH_HI_EN
                r_hi     <= w_acc_nxt;
`endif
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);
`ifdef BOOTH_HI_EN
    assign data_resultHI  = r_hi;
`endif
endmodule
